sync_fifo_control_unit: RTL

Single-clock FIFO controller for a dual-port RAM of depth 2**addr_size. It generates read and write addresses, write and read enables, and registered full/empty flags. It adds what the dual-clock controller lacks: an occupancy count, programmable almost-full and almost-empty thresholds, a write-through when full, and sticky overflow/underflow error flags. It is used wherever producer and consumer share one clock, so no pointer synchronisation is needed.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sync_fifo_control_unit_if.sv | 33 +++
 rtl/fifo_bin_ptr.sv | 21 ++
 rtl/sync_fifo_control_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth calculation, threshold legality and error-flag reset values.
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // Thresholds must leave almost_empty strictly below almost_full and fit the depth.
  function automatic bit thresholds_legal(input int unsigned addr_size,
                                          input int unsigned ae_level,
                                          input int unsigned af_level);
    return (addr_size >= 1) && (ae_level < af_level) && (af_level <= fifo_depth(addr_size));
  endfunction

  localparam logic OVERFLOW_RST  = 1'b0;
  localparam logic UNDERFLOW_RST = 1'b0;

endpackage

// File: rtl/sync_fifo_control_unit_if.sv
// Request/status bundle between a FIFO client (master) and the FIFO controller (slave).
interface sync_fifo_control_unit_if
  import fifo_pkg::*;
#(
  parameter int unsigned addr_size = 4
);
  logic                 wr;
  logic                 rd;
  logic                 clr_err;
  logic                 we_enable;
  logic                 rd_enable;
  logic [addr_size-1:0] addr_w;
  logic [addr_size-1:0] addr_r;
  logic [addr_size:0]   count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr, rd, clr_err,
    input  we_enable, rd_enable, addr_w, addr_r, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output we_enable, rd_enable, addr_w, addr_r, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_bin_ptr.sv
// Enabled binary pointer, one bit wider than the RAM address so full and empty differ.
module fifo_bin_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned width = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [width-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + width'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_control_unit.sv
// Single-clock FIFO controller: RAM strobes/addresses, occupancy, threshold and sticky error flags.
module sync_fifo_control_unit
  import fifo_pkg::*;
#(
  parameter int unsigned addr_size = 4,
  parameter int unsigned af_level  = fifo_depth(addr_size) - 2,
  parameter int unsigned ae_level  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sync_fifo_control_unit_if.slave  bus
);

  localparam int unsigned PW    = addr_size + 1;
  localparam int unsigned DEPTH = fifo_depth(addr_size);

  if (!thresholds_legal(addr_size, ae_level, af_level)) begin : g_bad_thresholds
    $error("sync_fifo_control_unit: need ae_level < af_level <= depth and addr_size >= 1");
  end

  logic [PW-1:0] ptr_w;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] count_q;
  logic [PW-1:0] next_count;
  logic          we_en_c;
  logic          rd_en_c;
  logic          full_q;
  logic          empty_q;
  logic          almost_full_q;
  logic          almost_empty_q;
  logic          overflow_q;
  logic          underflow_q;

  // A full FIFO can still accept a write when a read frees a slot in the same cycle.
  assign rd_en_c = bus.rd & ~empty_q;
  assign we_en_c = bus.wr & (~full_q | bus.rd);

  fifo_bin_ptr #(.width(PW)) u_ptr_w (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (we_en_c),
    .ptr     (ptr_w)
  );

  fifo_bin_ptr #(.width(PW)) u_ptr_r (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (rd_en_c),
    .ptr     (ptr_r)
  );

  always_comb begin
    next_count = count_q;
    unique case ({we_en_c, rd_en_c})
      2'b10:   next_count = count_q + PW'(1);
      2'b01:   next_count = count_q - PW'(1);
      default: next_count = count_q;
    endcase
  end

  // Every status flag is derived from the post-edge occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      count_q        <= next_count;
      full_q         <= (next_count == PW'(DEPTH));
      empty_q        <= (next_count == '0);
      almost_full_q  <= (32'(next_count) >= af_level);
      almost_empty_q <= (32'(next_count) <= ae_level);
    end
  end

  // Sticky errors: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= OVERFLOW_RST;
      underflow_q <= UNDERFLOW_RST;
    end else begin
      overflow_q  <= (bus.wr & ~we_en_c) | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.rd & empty_q)  | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.we_enable    = we_en_c;
  assign bus.rd_enable    = rd_en_c;
  assign bus.addr_w       = ptr_w[addr_size-1:0];
  assign bus.addr_r       = ptr_r[addr_size-1:0];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
